memory_island_bank_arbiter: RTL and testbench

Per-bank arbiter and response router for the memory island: it shares one SRAM bank port between a set of narrow requesters and a set of wide-split requesters. Wide requesters have priority by default, and a starvation counter periodically hands the bank to waiting narrow requesters. The arbiter returns each response to the requester that issued it. One instance sits in front of every bank, between the narrow/wide crossbars and the bank macro, and implements the island's WidePriorityWait policy.

---
 rtl/memory_island_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_memory_island_bank_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_island_bank_arbiter.sv
// Per-bank arbiter for the memory island. One SRAM bank port is shared between
// narrow and wide requesters. Wide wins by default; after WidePriorityWait
// consecutive starved cycles a pending narrow request wins one grant. Each
// response strobe is routed back to the requester that won the access.
module memory_island_bank_arbiter #(
   parameter int AddrWidth        = 16,
   parameter int DataWidth        = 32,
   parameter int NumNarrow        = 1,
   parameter int NumWide          = 1,
   parameter int WidePriorityWait = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumNarrow-1:0]                 narrow_req_i,
   output logic [NumNarrow-1:0]                 narrow_gnt_o,
   input  logic [NumNarrow-1:0][AddrWidth-1:0]  narrow_addr_i,
   input  logic [NumNarrow-1:0]                 narrow_we_i,
   input  logic [NumNarrow-1:0][DataWidth-1:0]  narrow_wdata_i,
   input  logic [NumNarrow-1:0][DataWidth/8-1:0] narrow_strb_i,
   output logic [NumNarrow-1:0]                 narrow_rvalid_o,
   output logic [NumNarrow-1:0][DataWidth-1:0]  narrow_rdata_o,
   input  logic [NumWide-1:0]                   wide_req_i,
   output logic [NumWide-1:0]                   wide_gnt_o,
   input  logic [NumWide-1:0][AddrWidth-1:0]    wide_addr_i,
   input  logic [NumWide-1:0]                   wide_we_i,
   input  logic [NumWide-1:0][DataWidth-1:0]    wide_wdata_i,
   input  logic [NumWide-1:0][DataWidth/8-1:0]  wide_strb_i,
   output logic [NumWide-1:0]                   wide_rvalid_o,
   output logic [NumWide-1:0][DataWidth-1:0]    wide_rdata_o,
   output logic                                 bank_req_o,
   output logic [AddrWidth-1:0]                 bank_addr_o,
   output logic                                 bank_we_o,
   output logic [DataWidth-1:0]                 bank_wdata_o,
   output logic [DataWidth/8-1:0]               bank_strb_o,
   input  logic [DataWidth-1:0]                 bank_rdata_i
);

   localparam int NIW  = (NumNarrow > 1) ? $clog2(NumNarrow) : 1;
   localparam int WIW  = (NumWide > 1) ? $clog2(NumWide) : 1;
   localparam int IdxW = (NIW > WIW) ? NIW : WIW;
   // Counter is kept one bit wide when WidePriorityWait is 0; it then stays 0.
   localparam int CntW = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;

   logic [NIW-1:0]  rr_n, n_idx;
   logic [WIW-1:0]  rr_w, w_idx;
   logic [CntW-1:0] starve_cnt;
   logic            n_found, w_found;
   logic            any_n, any_w, starved, gnt_n, gnt_w;
   logic            tag_valid, tag_wide;
   logic [IdxW-1:0] tag_idx;

   assign any_n   = |narrow_req_i;
   assign any_w   = |wide_req_i;
   assign starved = (WidePriorityWait != 0) && (starve_cnt == CntW'(WidePriorityWait));
   // Reset masks grants so nothing reaches the bank while rst_i is high.
   assign gnt_w   = !rst_i && any_w && !(any_n && starved);
   assign gnt_n   = !rst_i && any_n && !gnt_w;

   // Narrow round robin: first request at or above the pointer, else wrap to lowest.
   always_comb begin
      n_found = 1'b0;
      n_idx   = '0;
      for (int i = 0; i < NumNarrow; i++) begin
         if (!n_found && narrow_req_i[i] && i >= int'(rr_n)) begin
            n_found = 1'b1;
            n_idx   = NIW'(i);
         end
      end
      for (int i = 0; i < NumNarrow; i++) begin
         if (!n_found && narrow_req_i[i]) begin
            n_found = 1'b1;
            n_idx   = NIW'(i);
         end
      end
   end

   // Wide round robin, same search as the narrow side.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < NumWide; i++) begin
         if (!w_found && wide_req_i[i] && i >= int'(rr_w)) begin
            w_found = 1'b1;
            w_idx   = WIW'(i);
         end
      end
      for (int i = 0; i < NumWide; i++) begin
         if (!w_found && wide_req_i[i]) begin
            w_found = 1'b1;
            w_idx   = WIW'(i);
         end
      end
   end

   // Grant decode and bank payload mux from the winning requester.
   always_comb begin
      narrow_gnt_o = '0;
      wide_gnt_o   = '0;
      bank_addr_o  = '0;
      bank_we_o    = 1'b0;
      bank_wdata_o = '0;
      bank_strb_o  = '0;
      for (int i = 0; i < NumNarrow; i++) begin
         if (gnt_n && n_idx == NIW'(i)) begin
            narrow_gnt_o[i] = 1'b1;
            bank_addr_o     = narrow_addr_i[i];
            bank_we_o       = narrow_we_i[i];
            bank_wdata_o    = narrow_wdata_i[i];
            bank_strb_o     = narrow_strb_i[i];
         end
      end
      for (int i = 0; i < NumWide; i++) begin
         if (gnt_w && w_idx == WIW'(i)) begin
            wide_gnt_o[i] = 1'b1;
            bank_addr_o   = wide_addr_i[i];
            bank_we_o     = wide_we_i[i];
            bank_wdata_o  = wide_wdata_i[i];
            bank_strb_o   = wide_strb_i[i];
         end
      end
   end

   assign bank_req_o = (|narrow_gnt_o) | (|wide_gnt_o);

   // Pointers, starvation counter and response tag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_n       <= '0;
         rr_w       <= '0;
         starve_cnt <= '0;
         tag_valid  <= 1'b0;
         tag_wide   <= 1'b0;
         tag_idx    <= '0;
      end else begin
         if (gnt_n) rr_n <= (int'(n_idx) == NumNarrow - 1) ? '0 : n_idx + 1'b1;
         if (gnt_w) rr_w <= (int'(w_idx) == NumWide - 1) ? '0 : w_idx + 1'b1;
         if (WidePriorityWait == 0 || gnt_n || !any_n) begin
            starve_cnt <= '0;
         end else if (gnt_w && starve_cnt < CntW'(WidePriorityWait)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         tag_valid <= gnt_n | gnt_w;
         tag_wide  <= gnt_w;
         tag_idx   <= gnt_w ? IdxW'(w_idx) : IdxW'(n_idx);
      end
   end

   // Response strobe to the tagged requester; read data is broadcast.
   always_comb begin
      narrow_rvalid_o = '0;
      wide_rvalid_o   = '0;
      for (int i = 0; i < NumNarrow; i++) begin
         narrow_rvalid_o[i] = tag_valid && !tag_wide && tag_idx == IdxW'(i);
         narrow_rdata_o[i]  = bank_rdata_i;
      end
      for (int i = 0; i < NumWide; i++) begin
         wide_rvalid_o[i] = tag_valid && tag_wide && tag_idx == IdxW'(i);
         wide_rdata_o[i]  = bank_rdata_i;
      end
   end

endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Bench for memory_island_bank_arbiter: two instances share stimulus, one with
// WidePriorityWait=3 and one with WidePriorityWait=0, both tracked by a
// behavioural arbitration model.
module tb_memory_island_bank_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] nreq, wreq, nwe, wwe;
   logic [1:0][7:0] naddr, waddr;
   logic [1:0][31:0] nwd, wwd;
   logic [1:0][3:0] nst, wst;
   logic [31:0] bank_rdata;

   logic [1:0] ngnt, wgnt, nrv, wrv;
   logic [1:0][31:0] nrd, wrd;
   logic breq, bwe;
   logic [7:0] baddr;
   logic [31:0] bwd;
   logic [3:0] bst;

   logic [1:0] ngnt0, wgnt0, nrv0, wrv0;
   logic [1:0][31:0] nrd0, wrd0;
   logic breq0, bwe0;
   logic [7:0] baddr0;
   logic [31:0] bwd0;
   logic [3:0] bst0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_island_bank_arbiter #(.AddrWidth(8), .DataWidth(32), .NumNarrow(2), .NumWide(2),
      .WidePriorityWait(3)) dut (
      .clk_i(clk), .rst_i(rst),
      .narrow_req_i(nreq), .narrow_gnt_o(ngnt), .narrow_addr_i(naddr), .narrow_we_i(nwe),
      .narrow_wdata_i(nwd), .narrow_strb_i(nst), .narrow_rvalid_o(nrv), .narrow_rdata_o(nrd),
      .wide_req_i(wreq), .wide_gnt_o(wgnt), .wide_addr_i(waddr), .wide_we_i(wwe),
      .wide_wdata_i(wwd), .wide_strb_i(wst), .wide_rvalid_o(wrv), .wide_rdata_o(wrd),
      .bank_req_o(breq), .bank_addr_o(baddr), .bank_we_o(bwe), .bank_wdata_o(bwd),
      .bank_strb_o(bst), .bank_rdata_i(bank_rdata));

   memory_island_bank_arbiter #(.AddrWidth(8), .DataWidth(32), .NumNarrow(2), .NumWide(2),
      .WidePriorityWait(0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .narrow_req_i(nreq), .narrow_gnt_o(ngnt0), .narrow_addr_i(naddr), .narrow_we_i(nwe),
      .narrow_wdata_i(nwd), .narrow_strb_i(nst), .narrow_rvalid_o(nrv0), .narrow_rdata_o(nrd0),
      .wide_req_i(wreq), .wide_gnt_o(wgnt0), .wide_addr_i(waddr), .wide_we_i(wwe),
      .wide_wdata_i(wwd), .wide_strb_i(wst), .wide_rvalid_o(wrv0), .wide_rdata_o(wrd0),
      .bank_req_o(breq0), .bank_addr_o(baddr0), .bank_we_o(bwe0), .bank_wdata_o(bwd0),
      .bank_strb_o(bst0), .bank_rdata_i(bank_rdata));

   // Bank macro stand-in: registered read data, fixed pattern per address.
   always @(posedge clk) begin
      if (breq && !bwe)
         bank_rdata <= (baddr == 8'h10) ? 32'hDEADBEEF : {24'h5A5A5A, baddr};
   end

   // Reference model state, index 0 -> wait 3, index 1 -> wait 0.
   int waits[2] = '{3, 0};
   int m_ptr_n[2], m_ptr_w[2], m_starve[2];
   logic [1:0] tag_n[2], tag_w[2];
   logic [1:0] e_ngnt[2], e_wgnt[2], e_nrv[2], e_wrv[2];
   logic [7:0] e_addr;

   function automatic int rr_pick(input logic [1:0] r, input int p);
      for (int i = 0; i < 2; i++) begin
         int k;
         k = (p + i) % 2;
         if (((r >> k) & 2'b01) != 2'b00) return k;
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_ptr_n[c] = 0; m_ptr_w[c] = 0; m_starve[c] = 0;
         tag_n[c] = 2'b00; tag_w[c] = 2'b00;
      end
   endtask

   // Drive one cycle of requests at the falling edge, then predict outputs.
   task automatic drive(input logic [1:0] n, input logic [1:0] w, input bit randp);
      @(negedge clk);
      nreq = n;
      wreq = w;
      if (randp) begin
         naddr = 16'($urandom); waddr = 16'($urandom);
         nwe = 2'($urandom); wwe = 2'($urandom);
         nwd = {$urandom, $urandom}; wwd = {$urandom, $urandom};
         nst = 8'($urandom); wst = 8'($urandom);
      end
      #1;
      e_addr = 8'h00;
      for (int c = 0; c < 2; c++) begin
         int k;
         bit narrow_wins;
         e_nrv[c] = tag_n[c];
         e_wrv[c] = tag_w[c];
         e_ngnt[c] = 2'b00;
         e_wgnt[c] = 2'b00;
         narrow_wins = (n != 2'b00) &&
                       (w == 2'b00 || (waits[c] != 0 && m_starve[c] == waits[c]));
         if (narrow_wins) begin
            k = rr_pick(n, m_ptr_n[c]);
            e_ngnt[c] = 2'b01 << k;
            m_ptr_n[c] = (k + 1) % 2;
            m_starve[c] = 0;
            if (c == 0) e_addr = (k == 0) ? naddr[0] : naddr[1];
         end else if (w != 2'b00) begin
            k = rr_pick(w, m_ptr_w[c]);
            e_wgnt[c] = 2'b01 << k;
            m_ptr_w[c] = (k + 1) % 2;
            if (n == 2'b00) m_starve[c] = 0;
            else if (m_starve[c] < waits[c]) m_starve[c]++;
            if (c == 0) e_addr = (k == 0) ? waddr[0] : waddr[1];
         end else begin
            m_starve[c] = 0;
         end
         tag_n[c] = e_ngnt[c];
         tag_w[c] = e_wgnt[c];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      nreq = 2'b00;
      wreq = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      nreq = 2'b11;
      wreq = 2'b11;
      model_reset();
      #1;
      checks++;
      if ({ngnt, wgnt, breq, ngnt0, wgnt0, breq0} !== 10'b0) begin
         errors++;
         $display("FAIL reset_gnt: got %b required 0", {ngnt, wgnt, breq, ngnt0, wgnt0, breq0});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({nrv, wrv, nrv0, wrv0, ngnt, wgnt, breq} !== 13'b0) begin
         errors++;
         $display("FAIL reset_rvalid: got %b required 0", {nrv, wrv, nrv0, wrv0, ngnt, wgnt, breq});
      end
      rst = 1'b0;
      drive(2'b11, 2'b11, 1'b1);
      checks++;
      if (wgnt !== 2'b01 || ngnt !== 2'b00 || breq !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant: got w=%b n=%b req=%b required w=01 n=00 req=1",
                  wgnt, ngnt, breq);
      end
   endtask

   task automatic test_starvation();
      do_reset();
      for (int cyc = 0; cyc < 12; cyc++) begin
         drive(2'b01, 2'b01, 1'b1);
         checks++;
         if (ngnt !== ((cyc % 4 == 3) ? 2'b01 : 2'b00) || wgnt !== e_wgnt[0]) begin
            errors++;
            $display("FAIL starve_pattern cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, ngnt, wgnt, e_ngnt[0], e_wgnt[0]);
         end
         checks++;
         if (nrv !== e_nrv[0] || wrv !== e_wrv[0]) begin
            errors++;
            $display("FAIL starve_rvalid cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, nrv, wrv, e_nrv[0], e_wrv[0]);
         end
      end
   endtask

   task automatic test_absolute_priority();
      do_reset();
      for (int cyc = 0; cyc < 100; cyc++) begin
         drive(2'b01, 2'b01, 1'b1);
         checks++;
         if (ngnt0 !== 2'b00 || wgnt0 !== 2'b01) begin
            errors++;
            $display("FAIL abs_priority cyc %0d: got n=%b w=%b required n=00 w=01",
                     cyc, ngnt0, wgnt0);
         end
      end
      drive(2'b01, 2'b00, 1'b1);
      checks++;
      if (ngnt0 !== 2'b01 || breq0 !== 1'b1) begin
         errors++;
         $display("FAIL abs_priority_drop: got n=%b req=%b required n=01 req=1", ngnt0, breq0);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int cyc = 0; cyc < 8; cyc++) begin
         drive(2'b00, 2'b11, 1'b1);
         checks++;
         if (wgnt !== ((cyc % 2 == 0) ? 2'b01 : 2'b10) || baddr !== e_addr) begin
            errors++;
            $display("FAIL rr_grant cyc %0d: got w=%b addr=%h required w=%b addr=%h",
                     cyc, wgnt, baddr, (cyc % 2 == 0) ? 2'b01 : 2'b10, e_addr);
         end
         if (cyc > 0) begin
            checks++;
            if (wrv !== ((cyc % 2 == 1) ? 2'b01 : 2'b10) || nrv !== 2'b00) begin
               errors++;
               $display("FAIL rr_rvalid cyc %0d: got w=%b n=%b required w=%b n=00",
                        cyc, wrv, nrv, (cyc % 2 == 1) ? 2'b01 : 2'b10);
            end
         end
      end
   endtask

   task automatic test_read_routing();
      do_reset();
      naddr = {8'h10, 8'h33};
      nwe = 2'b00;
      drive(2'b10, 2'b00, 1'b0);
      checks++;
      if (ngnt !== 2'b10 || baddr !== 8'h10 || bwe !== 1'b0) begin
         errors++;
         $display("FAIL read_grant: got n=%b addr=%h we=%b required n=10 addr=10 we=0",
                  ngnt, baddr, bwe);
      end
      drive(2'b00, 2'b00, 1'b1);
      checks++;
      if (nrv !== 2'b10 || wrv !== 2'b00 || nrd[1] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_response: got nrv=%b wrv=%b rdata=%h required nrv=10 wrv=00 rdata=deadbeef",
                  nrv, wrv, nrd[1]);
      end
      drive(2'b00, 2'b00, 1'b1);
      checks++;
      if (nrv !== 2'b00 || wrv !== 2'b00) begin
         errors++;
         $display("FAIL read_single_pulse: got nrv=%b wrv=%b required 00", nrv, wrv);
      end
   endtask

   task automatic test_mid_burst_reset();
      do_reset();
      for (int cyc = 0; cyc < 3; cyc++) drive(2'b01, 2'b11, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (nrv !== 2'b00 || wrv !== 2'b00) begin
         errors++;
         $display("FAIL midreset_rvalid: got nrv=%b wrv=%b required 00", nrv, wrv);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         drive(2'b01, 2'b11, 1'b1);
         checks++;
         if (ngnt !== ((cyc == 3) ? 2'b01 : 2'b00) || wgnt !== e_wgnt[0] ||
             (cyc == 0 && wgnt !== 2'b01)) begin
            errors++;
            $display("FAIL midreset_grant cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, ngnt, wgnt, e_ngnt[0], e_wgnt[0]);
         end
         checks++;
         if (nrv !== e_nrv[0] || wrv !== e_wrv[0] || (cyc == 0 && (nrv | wrv) !== 2'b00)) begin
            errors++;
            $display("FAIL midreset_resp cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, nrv, wrv, e_nrv[0], e_wrv[0]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         drive(2'($urandom), 2'($urandom), 1'b1);
         checks++;
         if (ngnt !== e_ngnt[0] || wgnt !== e_wgnt[0] || breq !== |{e_ngnt[0], e_wgnt[0]}) begin
            errors++;
            $display("FAIL rand_gnt cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, ngnt, wgnt, e_ngnt[0], e_wgnt[0]);
         end
         checks++;
         if (ngnt0 !== e_ngnt[1] || wgnt0 !== e_wgnt[1]) begin
            errors++;
            $display("FAIL rand_gnt_wait0 cyc %0d: got n=%b w=%b required n=%b w=%b",
                     cyc, ngnt0, wgnt0, e_ngnt[1], e_wgnt[1]);
         end
         checks++;
         if (nrv !== e_nrv[0] || wrv !== e_wrv[0] || nrv0 !== e_nrv[1] || wrv0 !== e_wrv[1]) begin
            errors++;
            $display("FAIL rand_rvalid cyc %0d: got %b %b %b %b required %b %b %b %b",
                     cyc, nrv, wrv, nrv0, wrv0, e_nrv[0], e_wrv[0], e_nrv[1], e_wrv[1]);
         end
         if (breq === 1'b1) begin
            checks++;
            if (baddr !== e_addr) begin
               errors++;
               $display("FAIL rand_addr cyc %0d: got %h required %h", cyc, baddr, e_addr);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      nreq = 2'b00; wreq = 2'b00;
      naddr = '0; waddr = '0; nwe = '0; wwe = '0;
      nwd = '0; wwd = '0; nst = '0; wst = '0;
      model_reset();
      test_reset();
      test_starvation();
      test_absolute_priority();
      test_round_robin();
      test_read_routing();
      test_mid_burst_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
